audio_i2s_rx: RTL and testbench

AUDIO_I2S_RX -- requirements
Module: audio_i2s_rx

---
 rtl/audio_i2s_rx.sv | 176 +++++++++++++++++
 tb/tb_audio_i2s_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_rx.sv
// I2S capture: synchronises the codec ADC pins, deserialises left/right
// words and queues complete stereo pairs in a small FIFO.
module audio_i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  audio_BCLK,
  input  logic                  audio_ADCLRCK,
  input  logic                  audio_ADCDAT,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [15:0]           frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, SYNC, DELAY, SHIFT, DRAIN
  } state_t;

  state_t state, state_n;

  logic [2:0] bclk_q;
  logic [1:0] lrck_q;
  logic [1:0] dat_q;
  logic       lrck_last;
  logic       rise;
  logic       lrck;
  logic       dat;
  logic       lr_chg;

  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [DATA_WIDTH-1:0] left_word;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  chan, chan_n;
  logic                  hold_left;
  logic                  push_n;
  logic                  push_pend;

  logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, push_ok, drop;

  // bclk_q[2] is the edge-detect flop behind the 2-flop synchroniser
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_q    <= '0;
      lrck_q    <= '0;
      dat_q     <= '0;
      lrck_last <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[1:0], audio_BCLK};
      lrck_q <= {lrck_q[0], audio_ADCLRCK};
      dat_q  <= {dat_q[0], audio_ADCDAT};
      if (rise) lrck_last <= lrck;
    end
  end

  assign rise   = bclk_q[1] & ~bclk_q[2];
  assign lrck   = lrck_q[1];
  assign dat    = dat_q[1];
  assign lr_chg = lrck ^ lrck_last;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      chan      <= 1'b0;
      left_word <= '0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      chan      <= chan_n;
      push_pend <= push_n;
      if (hold_left) left_word <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    chan_n    = chan;
    hold_left = 1'b0;
    push_n    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = SYNC;
        SYNC: begin
          if (rise && lr_chg && !lrck) begin
            state_n = DELAY;
            chan_n  = 1'b0;
          end
        end
        DELAY, SHIFT: begin
          if (rise) begin
            if (lr_chg) begin
              // short word: drop it; a fresh left is needed
              state_n = lrck ? SYNC : DELAY;
              chan_n  = 1'b0;
            end else begin
              shreg_n = {shreg[DATA_WIDTH-2:0], dat};
              if (state == DELAY) begin
                cnt_n   = CW'(1);
                state_n = SHIFT;
              end else begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                  state_n   = DRAIN;
                  hold_left = ~chan;
                  push_n    = chan;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (rise && lr_chg) begin
            state_n = DELAY;
            chan_n  = lrck;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = sample_valid & sample_ready;
  assign push_ok = push_pend & (~full | pop);
  assign drop    = push_pend & full & ~pop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_l[wr_ptr[AW-1:0]] <= left_word;
        mem_r[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  assign sample_valid = ~empty;
  assign sample_left  = empty ? '0 : mem_l[rd_ptr[AW-1:0]];
  assign sample_right = empty ? '0 : mem_r[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: drives I2S frames, model queue
// holds the pairs a correct receiver must deliver.
module tb_audio_i2s_rx;
  localparam int DW = 24;
  localparam int FD = 2;

  logic clk = 0;
  logic rst_n = 1;
  logic bclk = 0, lrck = 0, dat = 0;
  logic enable = 0, ready = 0, ovf_clr = 0;
  logic [DW-1:0] s_left, s_right;
  logic s_valid, ovf;
  logic [15:0] fcount;

  always #5 clk = ~clk;

  audio_i2s_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .audio_BCLK(bclk),
    .audio_ADCLRCK(lrck),
    .audio_ADCDAT(dat),
    .enable(enable),
    .sample_left(s_left),
    .sample_right(s_right),
    .sample_valid(s_valid),
    .sample_ready(ready),
    .overflow(ovf),
    .overflow_clear(ovf_clr),
    .frame_count(fcount)
  );

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int exp_fc = 0;
  logic exp_ovf = 0;
  bit rand_ready = 0;
  bit count_ovf = 0;
  logic ovf_prev = 0;
  int ovf_rises = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: a finished pair enters the FIFO if there is room, else it is lost
  task automatic expect_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    if (exp_q.size() < FD) begin
      exp_q.push_back(p);
      exp_fc++;
    end else begin
      exp_ovf = 1;
    end
  endtask

  always @(negedge clk) begin
    pair_t p;
    if (rst_n && s_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %h/%h expected none",
                 s_left, s_right);
      end else begin
        p = exp_q.pop_front();
        check("left", 32'(s_left), 32'(p.l));
        check("right", 32'(s_right), 32'(p.r));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (count_ovf && ovf && !ovf_prev) ovf_rises <= ovf_rises + 1;
    ovf_prev <= ovf;
  end

  task automatic at_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic lr, input logic d);
    bclk = 0;
    lrck = lr;
    dat  = d;
    #37;
    bclk = 1;
    #37;
  endtask

  // slot 0 is the one-bit delay, slots 1..DW carry the word MSB first
  task automatic chan(input logic lr, input logic [DW-1:0] w,
                      input int from, input int to);
    for (int i = from; i < to; i++) begin
      logic d;
      d = (i >= 1 && i <= DW) ? w[DW-i] : 1'($urandom);
      slot(lr, d);
    end
  endtask

  task automatic pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                      input bit exp);
    if (exp) expect_pair(l, r);
    chan(0, l, 0, 32);
    chan(1, r, 0, 32);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    #1 rst_n = 0;
    #1;
    check("rst_valid", 32'(s_valid), 0);
    check("rst_left", 32'(s_left), 0);
    check("rst_right", 32'(s_right), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_fc", 32'(fcount), 0);
    repeat (3) at_clk;
    rst_n = 1;
    at_clk;
    enable = 1;
    ready = 1;
    chan(1, '0, 0, 32);
    check("no_early_valid", 32'(s_valid), 0);

    pair(24'h123456, 24'hABCDEF, 1);
    drain(200);
    check("fc_basic", 32'(fcount), 32'(exp_fc));

    rand_ready = 1;
    repeat (6) begin
      a = DW'($urandom);
      b = DW'($urandom);
      pair(a, b, 1);
    end
    drain(400);
    rand_ready = 0;
    at_clk;
    at_clk;
    ready = 1;
    check("fc_random", 32'(fcount), 32'(exp_fc));

    chan(0, DW'($urandom), 0, 11);
    chan(1, DW'($urandom), 0, 32);
    pair(24'h5A5A5A, 24'h800001, 1);
    drain(200);
    check("fc_short", 32'(fcount), 32'(exp_fc));

    at_clk;
    enable = 0;
    chan(0, 24'h111111, 0, 32);
    chan(1, 24'h222222, 0, 10);
    at_clk;
    enable = 1;
    chan(1, 24'h222222, 10, 32);
    pair(24'h7FFFFF, 24'h000000, 1);
    drain(200);
    check("fc_enable", 32'(fcount), 32'(exp_fc));

    at_clk;
    ready = 0;
    pair(24'hA00001, 24'hA00002, 1);
    pair(24'hB00001, 24'hB00002, 1);
    pair(24'hC00001, 24'hC00002, 1);
    check("ovf_set", 32'(ovf), 32'(exp_ovf));
    check("fc_full", 32'(fcount), 32'(exp_fc));
    check("valid_full", 32'(s_valid), 1);

    at_clk;
    ovf_clr = 1;
    count_ovf = 1;
    pair(24'hD00001, 24'hD00002, 1);
    count_ovf = 0;
    at_clk;
    ovf_clr = 0;
    exp_ovf = 0;
    at_clk;
    check("ovf_rise_under_clr", 32'(ovf_rises), 1);
    check("ovf_cleared", 32'(ovf), 32'(exp_ovf));
    check("fc_drop", 32'(fcount), 32'(exp_fc));

    ready = 1;
    drain(50);
    repeat (3) at_clk;
    check("empty_after_drain", 32'(s_valid), 0);

    at_clk;
    ready = 0;
    pair(24'hE00001, 24'hE00002, 1);
    chan(0, 24'hF0F0F0, 0, 12);
    rst_n = 0;
    #1;
    exp_q.delete();
    exp_fc = 0;
    exp_ovf = 0;
    check("mid_valid", 32'(s_valid), 0);
    check("mid_left", 32'(s_left), 0);
    check("mid_right", 32'(s_right), 0);
    check("mid_ovf", 32'(ovf), 0);
    check("mid_fc", 32'(fcount), 0);
    at_clk;
    rst_n = 1;
    at_clk;
    ready = 1;
    chan(0, 24'hF0F0F0, 12, 32);
    chan(1, 24'h0F0F0F, 0, 32);
    check("no_valid_after_rst", 32'(s_valid), 0);
    pair(24'h13579B, 24'h2468AC, 1);
    drain(200);
    check("fc_after_rst", 32'(fcount), 32'(exp_fc));

    repeat (20) at_clk;
    check("final_valid", 32'(s_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
